// File: rtl/exc_pkg.sv
// +--------------------------------------------------------------------------+
// | exc_pkg : shared FSM state type and cause codes for exc_irq_ctrl         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } exc_state_e;

  localparam int EXC_NONE = 0;
  localparam int EXC_SYNC = 1;

  // Width needed to hold a channel index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/irq_edge_latch.sv
// +--------------------------------------------------------------------------+
// | irq_edge_latch : one interrupt channel - optional 2-flop synchroniser    |
// | (IRQ_SYNC_EN), rising-edge detect and sticky pending bit. Rev 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_edge_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clr,
  output logic pending
);

  logic cur;
  logic prev_q, prev_d;
  logic arm_q, arm_d;
  logic pend_q, pend_d;
  logic rise;

`ifdef IRQ_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], irq_in};
  end

  // Synchroniser keeps running through reset so a held line is already
  // settled by the time edge detection is re-armed.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  assign cur = sync_q[1];
`else
  assign cur = irq_in;
`endif

  // arm_q blocks the first post-reset sample from being seen as an edge.
  always_comb begin
    prev_d = cur;
    arm_d  = 1'b1;
    rise   = arm_q & cur & ~prev_q;
    pend_d = rise | (pend_q & ~clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

endmodule

`default_nettype wire

// File: rtl/exc_irq_ctrl.sv
// +--------------------------------------------------------------------------+
// | exc_irq_ctrl : exception / interrupt controller, IDLE-REQ-SERVICE FSM,   |
// | lowest-index priority, sync exception first. Option: IRQ_SYNC_EN. Rev1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module exc_irq_ctrl
  import exc_pkg::*;
#(
  parameter int N_IRQ    = 4,
  parameter int ESW      = 4,
  parameter int IRQ_BASE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ExtIRQ,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             sync_exc,
  input  logic             ExcAck,
  input  logic             ERet,
  output logic             Exc,
  output logic [ESW-1:0]   EStatus,
  output logic [N_IRQ-1:0] ExtlAck,
  output logic             busy
);

  localparam int CW = idx_width(N_IRQ);

  exc_state_e       state_q, state_d;
  logic [CW-1:0]    chan_q, chan_d;
  logic             irq_q, irq_d;
  logic [ESW-1:0]   estatus_q, estatus_d;
  logic [N_IRQ-1:0] extlack_q, extlack_d;

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack_clr;
  logic [CW-1:0]    first_idx;

  for (genvar k = 0; k < N_IRQ; k++) begin : g_ch
    irq_edge_latch u_latch (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (ExtIRQ[k]),
      .clr     (ack_clr[k]),
      .pending (pending[k])
    );
  end

  assign eligible = pending & irq_mask;

  // Scan downward so the lowest set index wins.
  always_comb begin
    first_idx = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (eligible[k]) first_idx = CW'(k);
    end
  end

  // Only an interrupt-sourced exception acknowledges and clears its channel.
  always_comb begin
    ack_clr = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      ack_clr[k] = (state_q == ST_REQ) && ExcAck && irq_q && (chan_q == CW'(k));
    end
  end

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    irq_d     = irq_q;
    estatus_d = estatus_q;
    extlack_d = ack_clr;
    case (state_q)
      ST_IDLE: begin
        if (sync_exc) begin
          state_d   = ST_REQ;
          irq_d     = 1'b0;
          estatus_d = ESW'(EXC_SYNC);
        end else if (|eligible) begin
          state_d   = ST_REQ;
          irq_d     = 1'b1;
          chan_d    = first_idx;
          estatus_d = ESW'(IRQ_BASE) + ESW'(first_idx);
        end
      end
      ST_REQ: begin
        if (ExcAck) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (ERet) begin
          state_d   = ST_IDLE;
          estatus_d = ESW'(EXC_NONE);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        estatus_d = ESW'(EXC_NONE);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      chan_q    <= '0;
      irq_q     <= 1'b0;
      estatus_q <= '0;
      extlack_q <= '0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      irq_q     <= irq_d;
      estatus_q <= estatus_d;
      extlack_q <= extlack_d;
    end
  end

  assign Exc     = (state_q == ST_REQ);
  assign busy    = (state_q != ST_IDLE);
  assign EStatus = estatus_q;
  assign ExtlAck = extlack_q;

endmodule

`default_nettype wire

// File: tb/tb_exc_irq_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_exc_irq_ctrl : scoreboard bench for exc_irq_ctrl (defaults N_IRQ=4)   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_exc_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int IRQ_LAT = 4;
`else
  localparam int IRQ_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ExtIRQ;
  logic [3:0] irq_mask;
  logic       sync_exc;
  logic       ExcAck;
  logic       ERet;
  logic       Exc;
  logic [3:0] EStatus;
  logic [3:0] ExtlAck;
  logic       busy;

  typedef struct packed {
    logic [3:0] est;
    logic [3:0] ack;
  } exp_t;

  exp_t sb[$];
  int   n_vec     = 0;
  int   n_miscmp  = 0;

  exc_irq_ctrl #(.N_IRQ(4), .ESW(4), .IRQ_BASE(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .ExtIRQ   (ExtIRQ),
    .irq_mask (irq_mask),
    .sync_exc (sync_exc),
    .ExcAck   (ExcAck),
    .ERet     (ERet),
    .Exc      (Exc),
    .EStatus  (EStatus),
    .ExtlAck  (ExtlAck),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_exc(input int max_ticks, output int n);
    n = 0;
    while (Exc !== 1'b1 && n < max_ticks) begin
      tick();
      n++;
    end
    chk_eq("exc_rise", 32'(Exc), 32'd1);
  endtask

  // Pops the next expected exception, acknowledges and returns from it.
  task automatic finish_exc();
    exp_t e;
    if (sb.size() == 0) begin
      chk_eq("sb_underflow", 32'(sb.size()), 32'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    chk_eq("req_estatus", 32'(EStatus), 32'(e.est));
    chk_eq("req_busy", 32'(busy), 32'd1);
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    chk_eq("svc_exc", 32'(Exc), 32'd0);
    chk_eq("svc_ack", 32'(ExtlAck), 32'(e.ack));
    chk_eq("svc_estatus", 32'(EStatus), 32'(e.est));
    tick();
    chk_eq("ack_pulse_end", 32'(ExtlAck), 32'd0);
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
    chk_eq("eret_exc", 32'(Exc), 32'd0);
    chk_eq("eret_estatus", 32'(EStatus), 32'd0);
    chk_eq("eret_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    reset    = 1'b0;
    ExtIRQ   = '0;
    irq_mask = 4'hF;
    sync_exc = 1'b0;
    ExcAck   = 1'b0;
    ERet     = 1'b0;
    repeat (3) tick();
    chk_eq("rst_exc", 32'(Exc), 32'd0);
    chk_eq("rst_estatus", 32'(EStatus), 32'd0);
    chk_eq("rst_ack", 32'(ExtlAck), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    repeat (3) tick();

    // Stray ExcAck / ERet while idle must do nothing.
    ExcAck = 1'b1;
    ERet   = 1'b1;
    tick();
    ExcAck = 1'b0;
    ERet   = 1'b0;
    chk_eq("idle_ack_ignored", 32'(ExtlAck), 32'd0);
    chk_eq("idle_busy", 32'(busy), 32'd0);

    // Single channel 2; later edges and mask changes must not disturb it.
    ExtIRQ[2] = 1'b1;
    sb.push_back('{est: 4'hA, ack: 4'b0100});
    wait_exc(10, n);
    chk_eq("lat_irq", 32'(n), 32'(IRQ_LAT));
    ExtIRQ[0] = 1'b1;
    irq_mask  = 4'h1;
    sb.push_back('{est: 4'h8, ack: 4'b0001});
    ERet = 1'b1;
    tick();
    ERet = 1'b0;
    chk_eq("eret_in_req_ignored", 32'(Exc), 32'd1);
    finish_exc();
    irq_mask = 4'hF;
    wait_exc(10, n);
    finish_exc();
    ExtIRQ = '0;
    repeat (4) tick();

    // Simultaneous edges: lowest index first, then back-to-back service.
    ExtIRQ = 4'b1010;
    sb.push_back('{est: 4'h9, ack: 4'b0010});
    sb.push_back('{est: 4'hB, ack: 4'b1000});
    wait_exc(10, n);
    finish_exc();
    tick();
    chk_eq("b2b_exc", 32'(Exc), 32'd1);
    finish_exc();
    ExtIRQ = '0;
    repeat (4) tick();

    // Synchronous exception beats an interrupt in the same cycle.
    sync_exc  = 1'b1;
    ExtIRQ[0] = 1'b1;
    sb.push_back('{est: 4'h1, ack: 4'b0000});
    sb.push_back('{est: 4'h8, ack: 4'b0001});
    tick();
    sync_exc = 1'b0;
    chk_eq("lat_sync", 32'(Exc), 32'd1);
    finish_exc();
    wait_exc(IRQ_LAT + 2, n);
    finish_exc();
    ExtIRQ = '0;
    repeat (4) tick();

    // Masked pending is held, then served once enabled.
    irq_mask  = 4'h0;
    ExtIRQ[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | Exc;
    end
    chk_eq("masked_no_exc", 32'(seen), 32'd0);
    irq_mask[0] = 1'b1;
    sb.push_back('{est: 4'h8, ack: 4'b0001});
    wait_exc(2, n);
    finish_exc();
    ExtIRQ   = '0;
    irq_mask = 4'hF;
    repeat (4) tick();

    // Reset during SERVICE with channel 1 held high.
    ExtIRQ[1] = 1'b1;
    wait_exc(10, n);
    chk_eq("pre_rst_estatus", 32'(EStatus), 32'h9);
    ExcAck = 1'b1;
    tick();
    ExcAck = 1'b0;
    chk_eq("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk_eq("abort_exc", 32'(Exc), 32'd0);
    chk_eq("abort_estatus", 32'(EStatus), 32'd0);
    chk_eq("abort_ack", 32'(ExtlAck), 32'd0);
    chk_eq("abort_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | Exc | (|ExtlAck);
    end
    chk_eq("held_line_no_edge", 32'(seen), 32'd0);
    ExtIRQ[1] = 1'b0;
    repeat (4) tick();
    ExtIRQ[1] = 1'b1;
    sb.push_back('{est: 4'h9, ack: 4'b0010});
    wait_exc(10, n);
    chk_eq("lat_after_rst", 32'(n), 32'(IRQ_LAT));
    finish_exc();
    ExtIRQ = '0;
    repeat (2) tick();

    chk_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

`default_nettype wire
